hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Sequencing/hazard controller for the 5-stage RV32I pipeline (F/D/E/M/W).
//  Keeps its own shadow pipeline of {rd, RegWrite, isLoad} for E/M/W and drives
//  operand forwarding selects, load-use stalls and branch/jump flushes.
//  Freezes the whole pipeline while data memory is not ready; flags a fatal
//  memory timeout. Counts stall cycles for performance monitoring.
// PARAMETERS
//  TIMEOUT  default 64  max consecutive MemReadyM=0 cycles before MemErr
//  CNT_W    default 32  width of StallCnt performance counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-low
//  RS1_D      in   5      InstrD[19:15]
//  RS2_D      in   5      InstrD[24:20]
//  RD_D       in   5      InstrD[11:7]
//  RegWriteD  in   1      decode-stage RegWrite
//  ResultSrcD in   2      decode-stage ResultSrc; 2'b01 = load
//  PCSrcE     in   1      branch taken or jump resolved in E
//  MemReadyM  in   1      data memory ready; 0 = access in M not complete
//  StallF     out  1      hold PC
//  StallD     out  1      hold IF/ID register
//  FlushD     out  1      clear IF/ID register (bubble)
//  FlushE     out  1      clear ID/EX register (bubble)
//  Freeze     out  1      hold every pipeline register incl. PC
//  ForwardAE  out  2      SrcA mux: 00 RD1_E, 10 ALUResultM, 01 ResultW
//  ForwardBE  out  2      SrcB mux: same encoding
//  MemErr     out  1      sticky memory timeout flag
//  StallCnt   out  CNT_W  cycles with StallF=1 or Freeze=1, saturating
// BEHAVIOUR
//  Reset (rst=0, async): shadow E/M/W slots invalid (rd=0, RegWrite=0,
//   isLoad=0), RS1_E/RS2_E=0, state RUN, wait counter 0, MemErr=0, StallCnt=0;
//   all outputs 0. Reset mid-freeze/mid-ERR returns to RUN immediately.
//  Shadow pipeline advances on every clk edge with Freeze=0:
//   W<=M; M<=E; E<={RD_D,RegWriteD,ResultSrcD==01,RS1_D,RS2_D}. If
//   FlushE=1, E<=bubble (invalid). With Freeze=1, nothing advances.
//  Forwarding (combinational from shadow): ForwardAE=10 if M.RegWrite &&
//   M.rd!=0 && M.rd==RS1_E; else 01 if same for W; else 00. M beats W.
//   ForwardBE likewise with RS2_E. x0 is never forwarded.
//  Load-use: lwStall = E.isLoad && E.rd!=0 && (E.rd==RS1_D || E.rd==RS2_D).
//   lwStall -> StallF=StallD=1, FlushE=1. Net penalty: 1 cycle.
//  Control hazard: PCSrcE=1 -> FlushD=1, FlushE=1. Priority: PCSrcE beats
//   lwStall (StallF=StallD=0, since the D instruction is squashed).
//  FSM (state registered, outputs combinational):
//   RUN: Freeze=MemReadyM==0. MemReadyM=0 -> WAIT, waitcnt<=1.
//   WAIT: Freeze=~MemReadyM. MemReadyM=1 -> RUN (Freeze drops same cycle,
//    pipeline advances on that edge). Else waitcnt++; waitcnt==TIMEOUT ->
//    ERR.
//   ERR: Freeze=1, MemErr=1 permanently; exit only via reset.
//  While Freeze=1: StallF/StallD/FlushD/FlushE forced 0 (Freeze dominates);
//   forwarding selects still valid from held shadow state.
//  StallCnt increments when (StallF|Freeze), saturates at all-ones.
// TESTING
//  1. add x5 in E->M, next instr uses rs1=x5 -> ForwardAE=10 one cycle,
//     then 01 when x5 in W; rs1=x0 with rd=x0 writer -> ForwardAE=00.
//  2. lw x6; add x7,x6,x1 back-to-back -> StallF=StallD=FlushE=1 for exactly
//     1 cycle, then ForwardAE=01, StallCnt=1.
//  3. PCSrcE=1 same cycle as lwStall -> FlushD=FlushE=1, StallF=StallD=0.
//  4. MemReadyM=0 for 3 cycles -> Freeze=1 for 3 cycles, shadow unchanged,
//     StallCnt+=3, then RUN and normal advance.
//  5. MemReadyM held 0, TIMEOUT=8 -> MemErr=1 and Freeze=1 stick; rst=0
//     mid-ERR -> all outputs 0, state RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: shadow E/M/W destination
// tracking, operand forwarding, load-use stalls, branch flushes and data-memory freeze.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       RD_D,
    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic             PCSrcE,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             Freeze,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt
);

    typedef enum logic [1:0] {StRun, StWait, StErr} state_e;

    localparam int unsigned      WcW     = $clog2(TIMEOUT + 1) + 1;
    localparam logic [WcW-1:0]   WaitOne = WcW'(1);
    localparam logic [WcW-1:0]   WaitMax = WcW'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WcW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [4:0] e_rd_q, e_rd_d, e_rs1_q, e_rs1_d, e_rs2_q, e_rs2_d;
    logic       e_rw_q, e_rw_d, e_ld_q, e_ld_d;
    logic [4:0] m_rd_q, m_rd_d, w_rd_q, w_rd_d;
    logic       m_rw_q, m_rw_d, w_rw_q, w_rw_d;

    logic lw_stall;

    // Memory-wait FSM; wait_cnt counts consecutive not-ready cycles including the first.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        Freeze     = 1'b0;
        MemErr     = 1'b0;
        case (state_q)
            StRun: begin
                if (!MemReadyM) begin
                    Freeze     = 1'b1;
                    wait_cnt_d = WaitOne;
                    state_d    = (WaitOne >= WaitMax) ? StErr : StWait;
                end
            end
            StWait: begin
                if (MemReadyM) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else begin
                    Freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + WaitOne;
                    if (wait_cnt_d >= WaitMax) begin
                        state_d = StErr;
                    end
                end
            end
            StErr: begin
                Freeze = 1'b1;
                MemErr = 1'b1;
            end
            default: state_d = StRun;
        endcase
    end

    // A taken branch squashes the D instruction, so it overrides the load-use stall.
    always_comb begin
        lw_stall = e_ld_q && (e_rd_q != 5'd0) && ((e_rd_q == RS1_D) || (e_rd_q == RS2_D));
        StallF   = 1'b0;
        StallD   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        if (!Freeze) begin
            FlushD = PCSrcE;
            FlushE = PCSrcE | lw_stall;
            StallF = lw_stall & ~PCSrcE;
            StallD = lw_stall & ~PCSrcE;
        end
    end

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (m_rw_q && (m_rd_q != 5'd0) && (m_rd_q == e_rs1_q)) begin
            ForwardAE = 2'b10;
        end else if (w_rw_q && (w_rd_q != 5'd0) && (w_rd_q == e_rs1_q)) begin
            ForwardAE = 2'b01;
        end
        if (m_rw_q && (m_rd_q != 5'd0) && (m_rd_q == e_rs2_q)) begin
            ForwardBE = 2'b10;
        end else if (w_rw_q && (w_rd_q != 5'd0) && (w_rd_q == e_rs2_q)) begin
            ForwardBE = 2'b01;
        end
    end

    always_comb begin
        e_rd_d  = e_rd_q;
        e_rw_d  = e_rw_q;
        e_ld_d  = e_ld_q;
        e_rs1_d = e_rs1_q;
        e_rs2_d = e_rs2_q;
        m_rd_d  = m_rd_q;
        m_rw_d  = m_rw_q;
        w_rd_d  = w_rd_q;
        w_rw_d  = w_rw_q;
        if (!Freeze) begin
            w_rd_d = m_rd_q;
            w_rw_d = m_rw_q;
            m_rd_d = e_rd_q;
            m_rw_d = e_rw_q;
            if (FlushE) begin
                e_rd_d  = 5'd0;
                e_rw_d  = 1'b0;
                e_ld_d  = 1'b0;
                e_rs1_d = 5'd0;
                e_rs2_d = 5'd0;
            end else begin
                e_rd_d  = RD_D;
                e_rw_d  = RegWriteD;
                e_ld_d  = (ResultSrcD == 2'b01);
                e_rs1_d = RS1_D;
                e_rs2_d = RS2_D;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((StallF || Freeze) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
    end

    assign StallCnt = stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            e_rd_q      <= 5'd0;
            e_rw_q      <= 1'b0;
            e_ld_q      <= 1'b0;
            e_rs1_q     <= 5'd0;
            e_rs2_q     <= 5'd0;
            m_rd_q      <= 5'd0;
            m_rw_q      <= 1'b0;
            w_rd_q      <= 5'd0;
            w_rw_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            e_rd_q      <= e_rd_d;
            e_rw_q      <= e_rw_d;
            e_ld_q      <= e_ld_d;
            e_rs1_q     <= e_rs1_d;
            e_rs2_q     <= e_rs2_d;
            m_rd_q      <= m_rd_d;
            m_rw_q      <= m_rw_d;
            w_rd_q      <= w_rd_d;
            w_rw_q      <= w_rw_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed per-cycle vectors push expected outputs,
// a monitor pops and compares them just before each rising edge.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] RS1_D, RS2_D, RD_D;
    logic       RegWriteD;
    logic [1:0] ResultSrcD;
    logic       PCSrcE, MemReadyM;
    logic       StallF, StallD, FlushD, FlushE, Freeze, MemErr;
    logic [1:0] ForwardAE, ForwardBE;
    logic [3:0] StallCnt;

    hazard_ctrl #(
        .TIMEOUT(8),
        .CNT_W  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RS1_D     (RS1_D),
        .RS2_D     (RS2_D),
        .RD_D      (RD_D),
        .RegWriteD (RegWriteD),
        .ResultSrcD(ResultSrcD),
        .PCSrcE    (PCSrcE),
        .MemReadyM (MemReadyM),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .Freeze    (Freeze),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .MemErr    (MemErr),
        .StallCnt  (StallCnt)
    );

    typedef struct {
        int          id;
        logic [13:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   vec_id  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word layout: {StallF,StallD,FlushD,FlushE,Freeze,MemErr, ForwardAE, ForwardBE, StallCnt}
    task automatic step(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic rw, input logic [1:0] src,
                        input logic pc, input logic mr, input logic [5:0] fl,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [3:0] cnt);
        exp_t item;
        @(negedge clk);
        rst        = r;
        RS1_D      = s1;
        RS2_D      = s2;
        RD_D       = d;
        RegWriteD  = rw;
        ResultSrcD = src;
        PCSrcE     = pc;
        MemReadyM  = mr;
        item.id    = vec_id;
        item.exp   = {fl, fa, fb, cnt};
        sb.push_back(item);
        vec_id++;
    endtask

    always begin
        exp_t        e;
        logic [13:0] act;
        @(negedge clk);
        #2;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {StallF, StallD, FlushD, FlushE, Freeze, MemErr, ForwardAE, ForwardBE,
                   StallCnt};
            n_total++;
            if (act === e.exp) begin
                n_pass++;
            end else begin
                $display("FAIL vec%0d {sf,sd,fd,fe,fz,err}/fa/fb/cnt got %b/%b/%b/%0d want %b/%b/%b/%0d",
                         e.id, act[13:8], act[7:6], act[5:4], act[3:0],
                         e.exp[13:8], e.exp[7:6], e.exp[5:4], e.exp[3:0]);
            end
        end
    end

    initial begin
        rst        = 1'b0;
        RS1_D      = 5'd0;
        RS2_D      = 5'd0;
        RD_D       = 5'd0;
        RegWriteD  = 1'b0;
        ResultSrcD = 2'b00;
        PCSrcE     = 1'b0;
        MemReadyM  = 1'b1;

        // Reset, then forwarding from M and W, and x0 never forwarded
        step(0, 0, 0, 0, 0, 2'b00, 0, 1, 6'b000000, 2'b00, 2'b00, 4'd0);
        step(1, 1, 2, 5, 1, 2'b00, 0, 1, 6'b000000, 2'b00, 2'b00, 4'd0);
        step(1, 5, 0, 8, 1, 2'b00, 0, 1, 6'b000000, 2'b00, 2'b00, 4'd0);
        step(1, 5, 5, 9, 1, 2'b00, 0, 1, 6'b000000, 2'b10, 2'b00, 4'd0);
        step(1, 0, 0, 0, 1, 2'b00, 0, 1, 6'b000000, 2'b01, 2'b01, 4'd0);
        step(1, 0, 9, 10, 1, 2'b00, 0, 1, 6'b000000, 2'b00, 2'b00, 4'd0);
        step(1, 0, 0, 0, 0, 2'b00, 0, 1, 6'b000000, 2'b00, 2'b01, 4'd0);

        // Load-use: one stall cycle, then W forwarding
        step(1, 1, 0, 6, 1, 2'b01, 0, 1, 6'b000000, 2'b00, 2'b00, 4'd0);
        step(1, 6, 1, 7, 1, 2'b00, 0, 1, 6'b110100, 2'b00, 2'b00, 4'd0);
        step(1, 6, 1, 7, 1, 2'b00, 0, 1, 6'b000000, 2'b00, 2'b00, 4'd1);
        step(1, 0, 0, 0, 0, 2'b00, 0, 1, 6'b000000, 2'b01, 2'b00, 4'd1);

        // Branch in the same cycle as a load-use hazard
        step(1, 2, 0, 11, 1, 2'b01, 0, 1, 6'b000000, 2'b00, 2'b00, 4'd1);
        step(1, 11, 3, 12, 1, 2'b00, 1, 1, 6'b001100, 2'b00, 2'b00, 4'd1);
        step(1, 0, 0, 0, 0, 2'b00, 0, 1, 6'b000000, 2'b00, 2'b00, 4'd1);

        // Three-cycle memory wait holds the shadow pipeline
        step(1, 0, 0, 13, 1, 2'b00, 0, 1, 6'b000000, 2'b00, 2'b00, 4'd1);
        step(1, 13, 13, 14, 1, 2'b00, 0, 1, 6'b000000, 2'b00, 2'b00, 4'd1);
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, 6'b000010, 2'b10, 2'b10, 4'd1);
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, 6'b000010, 2'b10, 2'b10, 4'd2);
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, 6'b000010, 2'b10, 2'b10, 4'd3);
        step(1, 13, 14, 15, 1, 2'b00, 0, 1, 6'b000000, 2'b10, 2'b10, 4'd4);
        step(1, 0, 0, 0, 0, 2'b00, 0, 1, 6'b000000, 2'b01, 2'b10, 4'd4);

        // Timeout with a masked load-use hazard, then counter saturation
        step(1, 0, 0, 16, 1, 2'b01, 0, 1, 6'b000000, 2'b00, 2'b00, 4'd4);
        step(1, 16, 0, 17, 1, 2'b00, 0, 0, 6'b000010, 2'b00, 2'b00, 4'd4);
        for (int i = 0; i < 7; i++) begin
            step(1, 16, 0, 17, 1, 2'b00, 0, 0, 6'b000010, 2'b00, 2'b00, 4'(5 + i));
        end
        step(1, 16, 0, 17, 1, 2'b00, 0, 0, 6'b000011, 2'b00, 2'b00, 4'd12);
        step(1, 16, 0, 17, 1, 2'b00, 0, 0, 6'b000011, 2'b00, 2'b00, 4'd13);
        step(1, 16, 0, 17, 1, 2'b00, 0, 1, 6'b000011, 2'b00, 2'b00, 4'd14);
        step(1, 16, 0, 17, 1, 2'b00, 0, 1, 6'b000011, 2'b00, 2'b00, 4'd15);
        step(1, 16, 0, 17, 1, 2'b00, 0, 1, 6'b000011, 2'b00, 2'b00, 4'd15);

        // Reset out of the error state, then normal RUN behaviour
        step(0, 0, 0, 0, 0, 2'b00, 0, 1, 6'b000000, 2'b00, 2'b00, 4'd0);
        step(1, 0, 0, 0, 0, 2'b00, 0, 1, 6'b000000, 2'b00, 2'b00, 4'd0);
        step(1, 0, 0, 0, 0, 2'b00, 0, 0, 6'b000010, 2'b00, 2'b00, 4'd0);
        step(1, 0, 0, 0, 0, 2'b00, 0, 1, 6'b000000, 2'b00, 2'b00, 4'd1);

        @(negedge clk);
        #5;
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
